pass_sequencer: RTL and testbench

//   Parametrised pass controller for the layer datapath: sequences forward passes over
//   NUM_LAYERS layers (0..N-1), then, in training mode, backward passes (N-1..0), repeated
//   for a programmable epoch count. Sits between top-level control (start/abort) and the
//   per-layer compute units; emits one-hot pass enables and consumes per-layer done strobes.

---
 rtl/pass_sequencer_if.sv | 35 +++
 rtl/pass_sequencer.sv | 128 ++++++++++++
 tb/tb_pass_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pass_sequencer_if.sv
// rtl/pass_sequencer_if.sv - control/status bundle between top-level control and the pass sequencer
//
// Groups every pass_sequencer signal except clk_i/rst_i.
//   master : top-level control side; drives en/init/mode/epochs/layer_done/abort, observes outputs
//   slave  : sequencer side; consumes the controls, drives pass enables, layer, epoch and status
interface pass_sequencer_if #(
  parameter int NUM_LAYERS = 2,
  parameter int EPOCH_W    = 8
);
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                  en_i;
  logic                  init_i;
  logic                  mode_i;
  logic [EPOCH_W-1:0]    epochs_i;
  logic                  layer_done_i;
  logic                  abort_i;
  logic [NUM_LAYERS-1:0] fwd_pass_o;
  logic [NUM_LAYERS-1:0] bwd_pass_o;
  logic [LAYER_W-1:0]    layer_o;
  logic [EPOCH_W-1:0]    epoch_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  aborted_o;

  modport master (
    output en_i, init_i, mode_i, epochs_i, layer_done_i, abort_i,
    input  fwd_pass_o, bwd_pass_o, layer_o, epoch_o, busy_o, done_o, aborted_o
  );

  modport slave (
    input  en_i, init_i, mode_i, epochs_i, layer_done_i, abort_i,
    output fwd_pass_o, bwd_pass_o, layer_o, epoch_o, busy_o, done_o, aborted_o
  );
endinterface

// File: rtl/pass_sequencer.sv
// rtl/pass_sequencer.sv - forward/backward layer pass sequencer with epoch loop
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active high
//   bus    : pass_sequencer_if.slave
//            in : en_i (freeze when low), init_i, mode_i (1 = training), epochs_i (0 = 1),
//                 layer_done_i, abort_i
//            out: fwd_pass_o / bwd_pass_o (one-hot), layer_o, epoch_o, busy_o,
//                 done_o (completion pulse), aborted_o (abort pulse)
module pass_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int EPOCH_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pass_sequencer_if.slave   bus
);
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;
  logic               mode_q, mode_d;
  logic               aborted_q, aborted_d;
  logic               epoch_end;

  // One extra bit so the increment/compare can never wrap back to zero.
  logic [EPOCH_W:0]   epoch_inc;
  logic [EPOCH_W:0]   epoch_tgt;

  assign epoch_inc = {1'b0, epoch_q} + (EPOCH_W + 1)'(1);
  assign epoch_tgt = (epochs_q == '0) ? (EPOCH_W + 1)'(1) : {1'b0, epochs_q};

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    epoch_d   = epoch_q;
    epochs_d  = epochs_q;
    mode_d    = mode_q;
    aborted_d = 1'b0;
    epoch_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort_i is meaningless here, so init_i wins even if both are high.
        if (bus.init_i) begin
          state_d  = S_FWD;
          layer_d  = '0;
          epoch_d  = '0;
          mode_d   = bus.mode_i;
          epochs_d = bus.epochs_i;
        end
      end
      S_FWD: begin
        if (bus.abort_i) begin
          state_d   = S_IDLE;
          layer_d   = '0;
          aborted_d = 1'b1;
        end else if (bus.layer_done_i) begin
          if (layer_q != LAST_LAYER) begin
            layer_d = layer_q + LAYER_W'(1);
          end else if (mode_q) begin
            state_d = S_BWD;  // backward starts on the last layer
          end else begin
            epoch_end = 1'b1;
          end
        end
      end
      S_BWD: begin
        if (bus.abort_i) begin
          state_d   = S_IDLE;
          layer_d   = '0;
          aborted_d = 1'b1;
        end else if (bus.layer_done_i) begin
          if (layer_q != '0) begin
            layer_d = layer_q - LAYER_W'(1);
          end else begin
            epoch_end = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (epoch_end) begin
      epoch_d = epoch_inc[EPOCH_W-1:0];
      layer_d = '0;
      state_d = (epoch_inc == epoch_tgt) ? S_DONE : S_FWD;
    end
  end

  // en_i low freezes every register, including the abort pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      epoch_q   <= '0;
      epochs_q  <= '0;
      mode_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else if (bus.en_i) begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      epoch_q   <= epoch_d;
      epochs_q  <= epochs_d;
      mode_q    <= mode_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.fwd_pass_o = (state_q == S_FWD) ? (NUM_LAYERS'(1) << layer_q) : '0;
  assign bus.bwd_pass_o = (state_q == S_BWD) ? (NUM_LAYERS'(1) << layer_q) : '0;
  assign bus.layer_o    = layer_q;
  assign bus.epoch_o    = epoch_q;
  assign bus.busy_o     = (state_q == S_FWD) || (state_q == S_BWD);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.aborted_o  = aborted_q;
endmodule

// File: tb/tb_pass_sequencer.sv
// tb/tb_pass_sequencer.sv - directed self-checking bench for pass_sequencer (N=2 and N=3 instances)
module tb_pass_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pass_sequencer_if #(.NUM_LAYERS(2), .EPOCH_W(8)) p2 ();
  pass_sequencer_if #(.NUM_LAYERS(3), .EPOCH_W(8)) p3 ();

  pass_sequencer #(.NUM_LAYERS(2), .EPOCH_W(8)) dut2 (.clk_i(clk), .rst_i(rst), .bus(p2.slave));
  pass_sequencer #(.NUM_LAYERS(3), .EPOCH_W(8)) dut3 (.clk_i(clk), .rst_i(rst), .bus(p3.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int done2_cnt = 0;
  int bwd3_seen = 0;
  int onehot_bad = 0;
  int d0;

  always @(negedge clk) begin
    if (p2.done_o) done2_cnt++;
    if (p3.bwd_pass_o != '0) bwd3_seen++;
    if ($countones(p2.fwd_pass_o) + $countones(p2.bwd_pass_o) > 1) onehot_bad++;
    if ($countones(p3.fwd_pass_o) + $countones(p3.bwd_pass_o) > 1) onehot_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start2(input logic mode, input logic [7:0] epochs);
    p2.mode_i   = mode;
    p2.epochs_i = epochs;
    p2.init_i   = 1'b1;
    tick();
    p2.init_i   = 1'b0;
  endtask

  task automatic done2();
    p2.layer_done_i = 1'b1;
    tick();
    p2.layer_done_i = 1'b0;
  endtask

  task automatic done3();
    p3.layer_done_i = 1'b1;
    tick();
    p3.layer_done_i = 1'b0;
  endtask

  initial begin
    p2.en_i = 1'b1; p2.init_i = 1'b0; p2.mode_i = 1'b0; p2.epochs_i = '0;
    p2.layer_done_i = 1'b0; p2.abort_i = 1'b0;
    p3.en_i = 1'b1; p3.init_i = 1'b0; p3.mode_i = 1'b0; p3.epochs_i = '0;
    p3.layer_done_i = 1'b0; p3.abort_i = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_fwd", p2.fwd_pass_o, 0);
    chk("rst_busy", p2.busy_o, 0);
    chk("rst_epoch", p2.epoch_o, 0);
    chk("rst_done", p2.done_o, 0);
    rst = 1'b0;
    tick();

    // T1: reset mid-FWD at layer 1 clears outputs without waiting for a clock
    start2(1'b1, 8'd1);
    chk("t1_fwd0", p2.fwd_pass_o, 2'b01);
    done2();
    chk("t1_fwd1", p2.fwd_pass_o, 2'b10);
    chk("t1_layer1", p2.layer_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_fwd", p2.fwd_pass_o, 0);
    chk("t1_async_layer", p2.layer_o, 0);
    chk("t1_async_busy", p2.busy_o, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle_busy", p2.busy_o, 0);
    chk("t1_idle_fwd", p2.fwd_pass_o, 0);

    // T2: inference N=3, 1 epoch
    p3.mode_i = 1'b0; p3.epochs_i = 8'd1; p3.init_i = 1'b1;
    tick();
    p3.init_i = 1'b0;
    chk("t2_fwd0", p3.fwd_pass_o, 3'b001);
    done3();
    chk("t2_fwd1", p3.fwd_pass_o, 3'b010);
    done3();
    chk("t2_fwd2", p3.fwd_pass_o, 3'b100);
    chk("t2_layer2", p3.layer_o, 2);
    done3();
    chk("t2_done", p3.done_o, 1);
    chk("t2_done_fwd", p3.fwd_pass_o, 0);
    chk("t2_epoch", p3.epoch_o, 1);
    tick();
    chk("t2_done_pulse", p3.done_o, 0);
    chk("t2_epoch_hold", p3.epoch_o, 1);
    chk("t2_no_bwd", bwd3_seen, 0);

    // T3: training N=2, 2 epochs
    d0 = done2_cnt;
    start2(1'b1, 8'd2);
    chk("t3_e0_fwd0", p2.fwd_pass_o, 2'b01);
    chk("t3_e0_epoch", p2.epoch_o, 0);
    done2();
    chk("t3_e0_fwd1", p2.fwd_pass_o, 2'b10);
    done2();
    chk("t3_e0_bwd1", p2.bwd_pass_o, 2'b10);
    chk("t3_e0_bwd1_fwd", p2.fwd_pass_o, 0);
    chk("t3_e0_bwd1_layer", p2.layer_o, 1);
    done2();
    chk("t3_e0_bwd0", p2.bwd_pass_o, 2'b01);
    done2();
    chk("t3_e1_fwd0", p2.fwd_pass_o, 2'b01);
    chk("t3_e1_epoch", p2.epoch_o, 1);
    chk("t3_e1_bwd", p2.bwd_pass_o, 0);
    done2();
    chk("t3_e1_fwd1", p2.fwd_pass_o, 2'b10);
    done2();
    chk("t3_e1_bwd1", p2.bwd_pass_o, 2'b10);
    done2();
    chk("t3_e1_bwd0", p2.bwd_pass_o, 2'b01);
    chk("t3_e1_no_done", p2.done_o, 0);
    done2();
    chk("t3_done", p2.done_o, 1);
    chk("t3_epoch2", p2.epoch_o, 2);
    chk("t3_busy_done", p2.busy_o, 0);
    tick();
    chk("t3_idle_epoch", p2.epoch_o, 2);
    chk("t3_done_once", done2_cnt - d0, 1);

    // T4: abort coinciding with layer_done in BWD layer 1
    start2(1'b1, 8'd3);
    done2();
    done2();
    chk("t4_pre_bwd", p2.bwd_pass_o, 2'b10);
    p2.abort_i = 1'b1; p2.layer_done_i = 1'b1;
    tick();
    p2.abort_i = 1'b0; p2.layer_done_i = 1'b0;
    chk("t4_aborted", p2.aborted_o, 1);
    chk("t4_busy", p2.busy_o, 0);
    chk("t4_bwd", p2.bwd_pass_o, 0);
    chk("t4_no_done", p2.done_o, 0);
    chk("t4_epoch", p2.epoch_o, 0);
    tick();
    chk("t4_abort_pulse", p2.aborted_o, 0);
    p2.abort_i = 1'b1;
    tick();
    p2.abort_i = 1'b0;
    chk("t4_idle_abort", p2.aborted_o, 0);
    // init and abort together in IDLE start a run
    p2.abort_i = 1'b1; p2.mode_i = 1'b0; p2.epochs_i = 8'd1; p2.init_i = 1'b1;
    tick();
    p2.abort_i = 1'b0; p2.init_i = 1'b0;
    chk("t4_init_abort_busy", p2.busy_o, 1);
    chk("t4_init_abort_pulse", p2.aborted_o, 0);
    p2.abort_i = 1'b1;
    tick();
    p2.abort_i = 1'b0;
    chk("t4_second_abort", p2.aborted_o, 1);
    tick();

    // T5: en_i low freezes everything while layer_done pulses
    start2(1'b0, 8'd1);
    chk("t5_fwd0", p2.fwd_pass_o, 2'b01);
    p2.en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p2.layer_done_i = i[0] ? 1'b0 : 1'b1;
      tick();
      chk("t5_frozen_fwd", p2.fwd_pass_o, 2'b01);
    end
    p2.layer_done_i = 1'b0;
    chk("t5_frozen_layer", p2.layer_o, 0);
    p2.en_i = 1'b1;
    tick();
    chk("t5_resume_hold", p2.fwd_pass_o, 2'b01);
    done2();
    chk("t5_resume_fwd1", p2.fwd_pass_o, 2'b10);
    done2();
    chk("t5_done", p2.done_o, 1);
    tick();

    // T6: epochs 0 behaves as 1; stray init while busy is ignored
    d0 = done2_cnt;
    start2(1'b0, 8'd0);
    chk("t6_fwd0", p2.fwd_pass_o, 2'b01);
    p2.init_i = 1'b1;
    done2();
    chk("t6_fwd1", p2.fwd_pass_o, 2'b10);
    chk("t6_epoch0", p2.epoch_o, 0);
    done2();
    chk("t6_done", p2.done_o, 1);
    chk("t6_epoch1", p2.epoch_o, 1);
    p2.init_i = 1'b0;
    tick();
    tick();
    chk("t6_idle", p2.busy_o, 0);
    chk("t6_done_once", done2_cnt - d0, 1);

    chk("onehot", onehot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
